// File: rtl/sweep_counter.sv
// Bounded up/down sweep generator with one-shot and continuous modes.
// Optional build macro SWEEP_BOUNCE_EN: continuous mode bounces between LO and HI instead of reloading.
module sweep_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LO    = 0,
  parameter int unsigned HI    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             cont,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] i,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      wraps
);

  localparam int unsigned WX = WIDTH + 1;
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
  localparam logic [WIDTH:0]   LO_X = WX'(LO);
  localparam logic [WIDTH:0]   HI_X = WX'(HI);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             cont_q, cont_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] i_d;
  logic             valid_d, busy_d, done_d;
  logic [15:0]      wraps_d;
`ifdef SWEEP_BOUNCE_EN
  logic             sdir_q, sdir_d;
`endif

  // Bound test is done one bit wider so i never wraps modulo 2^WIDTH.
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   floor_x;
  logic             up_end, dn_end, at_bound;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] start_val;
  logic [15:0]      wraps_inc;

  always_comb begin
    sum_x     = {1'b0, i} + {1'b0, step_q};
    floor_x   = LO_X + {1'b0, step_q};
    up_end    = sum_x > HI_X;
    dn_end    = {1'b0, i} < floor_x;
    at_bound  = dir_q ? dn_end : up_end;
    next_val  = dir_q ? (i - step_q) : (i + step_q);
    start_val = dir_q ? HI_V : LO_V;
    wraps_inc = (wraps != 16'hFFFF) ? (wraps + 16'd1) : wraps;
  end

  // Next-state and next-output logic; stop overrides everything except reset.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    step_d  = step_q;
    i_d     = i;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wraps_d = wraps;
`ifdef SWEEP_BOUNCE_EN
    sdir_d  = sdir_q;
`endif
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = RUN;
            dir_d   = dir;
            cont_d  = cont;
            step_d  = (step == '0) ? WIDTH'(1) : step;
            i_d     = dir ? HI_V : LO_V;
            wraps_d = 16'd0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
`ifdef SWEEP_BOUNCE_EN
            sdir_d  = dir;
`endif
          end
        end
        RUN: begin
          busy_d = 1'b1;
          if (!pause) begin
            if (!at_bound) begin
              i_d     = next_val;
              valid_d = 1'b1;
            end else if (cont_q) begin
              valid_d = 1'b1;
`ifdef SWEEP_BOUNCE_EN
              // Clamp to the bound just reached and turn around; a full
              // round trip completes when the start-side bound is reached.
              dir_d = ~dir_q;
              i_d   = dir_q ? LO_V : HI_V;
              if (dir_q != sdir_q) begin
                wraps_d = wraps_inc;
              end
`else
              i_d     = start_val;
              wraps_d = wraps_inc;
`endif
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      step_q  <= '0;
      i       <= LO_V;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wraps   <= 16'd0;
`ifdef SWEEP_BOUNCE_EN
      sdir_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      step_q  <= step_d;
      i       <= i_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      wraps   <= wraps_d;
`ifdef SWEEP_BOUNCE_EN
      sdir_q  <= sdir_d;
`endif
    end
  end

endmodule

// File: tb/tb_sweep_counter.sv
// Directed self-checking bench for sweep_counter (WIDTH=8, LO=0, HI=255).
module tb_sweep_counter;

  logic       clk = 1'b0;
  logic       rst, en, stop, pause, dir, cont;
  logic [7:0] step;
  logic [7:0] i;
  logic       valid, busy, done;
  logic [15:0] wraps;

  int n_tests = 0;
  int n_fail  = 0;

  int c_i[10];
  int c_w[10];

  always #5 clk = ~clk;

  sweep_counter #(.WIDTH(8), .LO(0), .HI(255)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .stop  (stop),
    .pause (pause),
    .dir   (dir),
    .cont  (cont),
    .step  (step),
    .i     (i),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .wraps (wraps)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic d, input logic c, input logic [7:0] s);
    dir  = d;
    cont = c;
    step = s;
    en   = 1'b1;
    tick();
    en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stop = 1'b0; pause = 1'b0;
    dir = 1'b0; cont = 1'b0; step = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_i",     32'(i),     32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_wraps", 32'(wraps), 32'd0);

    // en together with stop keeps the block idle
    en = 1'b1; stop = 1'b1;
    tick();
    en = 1'b0; stop = 1'b0;
    check("enstop_busy",  32'(busy),  32'd0);
    check("enstop_valid", 32'(valid), 32'd0);

    // one-shot up, step 1: full 0..255 sweep
    start(1'b0, 1'b0, 8'd1);
    for (int k = 0; k < 256; k++) begin
      check("up1_i",     32'(i),     32'(k));
      check("up1_valid", 32'(valid), 32'd1);
      check("up1_busy",  32'(busy),  32'd1);
      tick();
    end
    check("up1_done",    32'(done),  32'd1);
    check("up1_dvalid",  32'(valid), 32'd0);
    check("up1_dbusy",   32'(busy),  32'd0);
    check("up1_di",      32'(i),     32'd255);
    tick();
    check("up1_done_off", 32'(done),  32'd0);
    check("up1_idle_i",   32'(i),     32'd255);
    check("up1_idle_bsy", 32'(busy),  32'd0);
    check("up1_idle_vld", 32'(valid), 32'd0);

    // one-shot down, step 100
    c_i[0] = 255; c_i[1] = 155; c_i[2] = 55;
    start(1'b1, 1'b0, 8'd100);
    for (int k = 0; k < 3; k++) begin
      check("dn100_i",     32'(i),     32'(c_i[k]));
      check("dn100_valid", 32'(valid), 32'd1);
      tick();
    end
    check("dn100_done",  32'(done),  32'd1);
    check("dn100_valid", 32'(valid), 32'd0);
    check("dn100_i",     32'(i),     32'd55);
    tick();
    check("dn100_off",   32'(done),  32'd0);
    check("dn100_busy",  32'(busy),  32'd0);

    // continuous up, step 64
`ifdef SWEEP_BOUNCE_EN
    c_i = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};
    c_w = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`else
    c_i = '{0, 64, 128, 192, 0, 64, 128, 192, 0, 64};
    c_w = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
`endif
    start(1'b0, 1'b1, 8'd64);
    for (int k = 0; k < 10; k++) begin
      check("cont_i",     32'(i),     32'(c_i[k]));
      check("cont_valid", 32'(valid), 32'd1);
      check("cont_wraps", 32'(wraps), 32'(c_w[k]));
      check("cont_done",  32'(done),  32'd0);
      if (k < 9) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy",  32'(busy),  32'd0);
    check("stop_valid", 32'(valid), 32'd0);
    check("stop_done",  32'(done),  32'd0);
    check("stop_i",     32'(i),     32'd64);
    check("stop_wraps", 32'(wraps), 32'(c_w[9]));
    tick();
    check("stop_stay",  32'(busy),  32'd0);

    // pause at 10 for five cycles, start clears wraps
    start(1'b0, 1'b0, 8'd1);
    check("pause_wclr", 32'(wraps), 32'd0);
    repeat (10) tick();
    check("pause_i10", 32'(i),     32'd10);
    check("pause_v10", 32'(valid), 32'd1);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("pause_hold_i", 32'(i),     32'd10);
      check("pause_hold_v", 32'(valid), 32'd0);
      check("pause_hold_b", 32'(busy),  32'd1);
    end
    pause = 1'b0;
    tick();
    check("pause_resume_i", 32'(i),     32'd11);
    check("pause_resume_v", 32'(valid), 32'd1);
    // stop wins over pause
    stop = 1'b1; pause = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    check("pstop_busy", 32'(busy),  32'd0);
    check("pstop_i",    32'(i),     32'd11);
    check("pstop_v",    32'(valid), 32'd0);

    // step 0 acts as step 1; en while busy ignored; reset mid-sweep
    start(1'b0, 1'b0, 8'd0);
    check("s0_i0", 32'(i), 32'd0);
    tick();
    check("s0_i1", 32'(i), 32'd1);
    en = 1'b1;
    repeat (76) tick();
    check("s0_i77",  32'(i),     32'd77);
    check("s0_busy", 32'(busy),  32'd1);
    check("s0_vld",  32'(valid), 32'd1);
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_i",     32'(i),     32'd0);
    check("mrst_busy",  32'(busy),  32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_done",  32'(done),  32'd0);
    check("mrst_wraps", 32'(wraps), 32'd0);
    tick();
    check("mrst_idle",  32'(busy),  32'd0);

`ifdef SWEEP_BOUNCE_EN
    // bounce, step 100
    c_i = '{0, 100, 200, 255, 155, 55, 0, 100, 200, 255};
    c_w = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    start(1'b0, 1'b1, 8'd100);
    for (int k = 0; k < 10; k++) begin
      check("bnc_i",     32'(i),     32'(c_i[k]));
      check("bnc_valid", 32'(valid), 32'd1);
      check("bnc_wraps", 32'(wraps), 32'(c_w[k]));
      if (k < 9) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("bnc_stop", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_counter.md
SWEEP_COUNTER -- requirements
Module: sweep_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count width in bits.
REQ-002 SHALL have parameter LO, default 0, lower sweep bound; LO < HI <= 2^WIDTH-1.
REQ-003 SHALL have parameter HI, default 255, upper sweep bound.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port en  input  1  start request, sampled each cycle.
REQ-007 SHALL have port stop  input  1  abort request; returns the block to IDLE.
REQ-008 SHALL have port pause  input  1  freezes the sweep while high.
REQ-009 SHALL have port dir  input  1  0 = up (LO toward HI), 1 = down (HI toward LO); latched at start.
REQ-010 SHALL have port cont  input  1  0 = one-shot, 1 = continuous; latched at start.
REQ-011 SHALL have port step  input  WIDTH  increment magnitude; latched at start; 0 is treated as 1.
REQ-012 SHALL have port i  output  WIDTH  current sweep value.
REQ-013 SHALL have port valid  output  1  high for exactly the cycles in which i presents a new sweep value.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse at one-shot completion.
REQ-016 SHALL have port wraps  output  16  count of completed sweeps in continuous mode; saturates at 16'hFFFF.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 In IDLE, en=1 and stop=0 SHALL latch dir, cont and step, load i with LO (dir=0) or HI (dir=1), clear wraps and enter RUN.
REQ-019 The first value SHALL appear with valid=1 in the cycle after en is sampled (1-cycle latency).
REQ-020 In RUN with pause=0, i SHALL advance by the latched step each cycle, with valid=1 on every advanced value.
REQ-021 In RUN with pause=1, i SHALL hold, valid SHALL be 0 and busy SHALL stay 1.
REQ-022 The bound test SHALL be evaluated at WIDTH+1 bits: up ends when i+step > HI; down ends when i < LO+step; no modular wrap of i is permitted.
REQ-023 At the bound in one-shot mode, the block SHALL enter DONE (valid=0, done=1 for one cycle) and then IDLE; i SHALL hold its last value.
REQ-024 At the bound in continuous mode, i SHALL reload its start value in the next cycle with valid=1, and wraps SHALL increment.
REQ-025 stop SHALL have priority over pause, advance and bound handling; in any state it SHALL force IDLE next cycle with valid=0, done=0 and i held.
REQ-026 en in RUN or DONE SHALL be ignored; en and stop together in IDLE SHALL leave the block in IDLE.
REQ-027 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, i=LO, valid=0, busy=0, done=0, wraps=0 and clear the latched dir, cont and step, overriding every other input including mid-sweep.

Configuration
REQ-029 Macro SWEEP_BOUNCE_EN defined: in continuous mode, reaching a bound SHALL reverse the direction instead of reloading, clamp i to that bound (HI or LO) with valid=1, and increment wraps once per full up-plus-down cycle.
REQ-030 Macro SWEEP_BOUNCE_EN undefined: no bounce logic SHALL be present, and continuous mode SHALL behave exactly as REQ-024.

Verification
REQ-031 Scenario: reset; en pulse, dir=0, cont=0, step=1 -> i = 0..255 on 256 consecutive valid cycles, then done=1 for exactly one cycle, then IDLE with i=255.
REQ-032 Scenario: dir=1, step=100, one-shot -> valid values 255, 155, 55, then done; 55-100 is never emitted.
REQ-033 Scenario: cont=1, step=64, up -> 0, 64, 128, 192, 0, ... with wraps incrementing on each return to 0; stop -> IDLE next cycle, busy=0.
REQ-034 Scenario: pause high for 5 cycles mid-sweep at i=10 -> i holds 10 with valid=0 for those cycles, then resumes at 11.
REQ-035 Scenario: rst asserted while i=77 in RUN -> next cycle i=0, busy=0, wraps=0; en while busy is ignored; step=0 behaves as step=1.
REQ-036 Scenario: SWEEP_BOUNCE_EN defined, step=100, cont=1 -> 0, 100, 200, 255, 155, 55, 0, 100, ... with wraps=1 after the first return to 0.
